// File: rtl/exp_ctrl.sv
// rtl/exp_ctrl.sv - exception/interrupt prioritiser with CP0-lite state (optional timer: EXP_CTRL_TIMER_EN)
module exp_ctrl #(
    parameter logic [7:0] EXP_NONE     = 8'hFF,
    parameter logic [7:0] EXP_SYSCALL  = 8'h50,
    parameter logic [7:0] EXP_INT_BASE = 8'h20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [19:0] excp_req_i,
    input  logic        syscall_i,
    input  logic [31:0] excp_pc_i,
    input  logic [5:0]  int_i,
    input  logic        eret_i,
    input  logic        mtc0_we_i,
    input  logic [4:0]  mtc0_addr_i,
    input  logic [31:0] mtc0_data_i,
    input  logic [4:0]  mfc0_addr_i,
    output logic [31:0] mfc0_data_o,
    output logic [7:0]  exp_no_o,
    output logic [31:0] epc_o,
    output logic        timer_int_o
);

    localparam logic [4:0] ADDR_COUNT   = 5'd9;
    localparam logic [4:0] ADDR_COMPARE = 5'd11;
    localparam logic [4:0] ADDR_STATUS  = 5'd12;
    localparam logic [4:0] ADDR_CAUSE   = 5'd13;
    localparam logic [4:0] ADDR_EPC     = 5'd14;

    logic        ie_q;
    logic        exl_q;
    logic [7:0]  im_q;
    logic [1:0]  ip_sw_q;
    logic [4:0]  exc_code_q;
    logic [31:0] epc_q;
    logic [31:0] count_rd;
    logic [31:0] compare_rd;

    logic [7:0]  ip;
    logic [7:0]  ip_masked;
    logic [4:0]  sync_code;
    logic [2:0]  irq_code;
    logic        taken;
    logic [4:0]  taken_exc_code;

    wire wr_status = mtc0_we_i && (mtc0_addr_i == ADDR_STATUS);
    wire wr_cause  = mtc0_we_i && (mtc0_addr_i == ADDR_CAUSE);
    wire wr_epc    = mtc0_we_i && (mtc0_addr_i == ADDR_EPC);

    // Hardware IP bits follow the pins every cycle; only IP[1:0] are software state.
    assign ip        = {int_i[5] | timer_int_o, int_i[4:0], ip_sw_q};
    assign ip_masked = ip & im_q;

    // Priority resolution: lowest sync request, then syscall, then highest enabled interrupt.
    always_comb begin
        sync_code      = 5'd0;
        irq_code       = 3'd0;
        exp_no_o       = EXP_NONE;
        taken_exc_code = 5'd0;
        for (int i = 19; i >= 0; i--) begin
            if (excp_req_i[i]) sync_code = 5'(i);
        end
        for (int i = 0; i < 8; i++) begin
            if (ip_masked[i]) irq_code = 3'(i);
        end
        if (|excp_req_i) begin
            exp_no_o       = {3'b000, sync_code};
            taken_exc_code = sync_code;
        end else if (syscall_i) begin
            exp_no_o       = EXP_SYSCALL;
            taken_exc_code = 5'd8;
        end else if (ie_q && !exl_q && (|ip_masked)) begin
            exp_no_o       = EXP_INT_BASE + {5'b00000, irq_code};
            taken_exc_code = 5'd0;
        end
    end

    assign taken = (exp_no_o != EXP_NONE);

    // STATUS/CAUSE/EPC: mtc0 first, then eret, then a taken event overrides EXL/ExcCode/EPC.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ie_q       <= 1'b0;
            exl_q      <= 1'b0;
            im_q       <= 8'h00;
            ip_sw_q    <= 2'b00;
            exc_code_q <= 5'd0;
            epc_q      <= 32'h0;
        end else begin
            if (wr_status) begin
                ie_q  <= mtc0_data_i[0];
                exl_q <= mtc0_data_i[1];
                im_q  <= mtc0_data_i[15:8];
            end
            if (wr_cause) ip_sw_q <= mtc0_data_i[9:8];
            if (wr_epc) epc_q <= mtc0_data_i;
            if (eret_i && !taken) exl_q <= 1'b0;
            if (taken) begin
                exc_code_q <= taken_exc_code;
                exl_q      <= 1'b1;
                if (!exl_q) epc_q <= excp_pc_i;
            end
        end
    end

`ifdef EXP_CTRL_TIMER_EN
    logic [31:0] count_q;
    logic [31:0] compare_q;
    logic [31:0] count_next;
    logic        timer_q;

    wire wr_count   = mtc0_we_i && (mtc0_addr_i == ADDR_COUNT);
    wire wr_compare = mtc0_we_i && (mtc0_addr_i == ADDR_COMPARE);

    assign count_next = wr_count ? mtc0_data_i : count_q + 32'd1;

    // Free-running counter; the timer flag latches on a match and only a COMPARE write clears it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q   <= 32'h0;
            compare_q <= 32'hFFFF_FFFF;
            timer_q   <= 1'b0;
        end else begin
            count_q <= count_next;
            if (wr_compare) begin
                compare_q <= mtc0_data_i;
                timer_q   <= 1'b0;
            end else if (count_next == compare_q) begin
                timer_q <= 1'b1;
            end
        end
    end

    assign timer_int_o = timer_q;
    assign count_rd    = count_q;
    assign compare_rd  = compare_q;
`else
    assign timer_int_o = 1'b0;
    assign count_rd    = 32'h0;
    assign compare_rd  = 32'h0;
`endif

    // CP0 read mux; unmapped addresses read as zero.
    always_comb begin
        mfc0_data_o = 32'h0;
        case (mfc0_addr_i)
            ADDR_COUNT:   mfc0_data_o = count_rd;
            ADDR_COMPARE: mfc0_data_o = compare_rd;
            ADDR_STATUS:  mfc0_data_o = {16'h0, im_q, 6'b000000, exl_q, ie_q};
            ADDR_CAUSE:   mfc0_data_o = {16'h0, ip, 1'b0, exc_code_q, 2'b00};
            ADDR_EPC:     mfc0_data_o = epc_q;
            default:      mfc0_data_o = 32'h0;
        endcase
    end

    assign epc_o = epc_q;

endmodule

// File: tb/tb_exp_ctrl.sv
// tb/tb_exp_ctrl.sv - randomized model-checked bench for exp_ctrl
module tb_exp_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [19:0] excp_req = '0;
    logic        syscall = 1'b0;
    logic [31:0] excp_pc = '0;
    logic [5:0]  int_lines = '0;
    logic        eret = 1'b0;
    logic        mtc0_we = 1'b0;
    logic [4:0]  mtc0_addr = '0;
    logic [31:0] mtc0_data = '0;
    logic [4:0]  mfc0_addr = 5'd12;
    logic [31:0] mfc0_data;
    logic [7:0]  exp_no;
    logic [31:0] epc;
    logic        timer_int;

    int tests = 0;
    int fails = 0;

    exp_ctrl dut (
        .clk(clk), .rst(rst), .excp_req_i(excp_req), .syscall_i(syscall),
        .excp_pc_i(excp_pc), .int_i(int_lines), .eret_i(eret),
        .mtc0_we_i(mtc0_we), .mtc0_addr_i(mtc0_addr), .mtc0_data_i(mtc0_data),
        .mfc0_addr_i(mfc0_addr), .mfc0_data_o(mfc0_data), .exp_no_o(exp_no),
        .epc_o(epc), .timer_int_o(timer_int)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            if (fails <= 30) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic        m_ie, m_exl, m_timer;
    logic [7:0]  m_im;
    logic [1:0]  m_ipsw;
    logic [4:0]  m_exc;
    logic [31:0] m_epc, m_count, m_cmp;

    function automatic logic [7:0] m_ip();
        return {int_lines[5] | m_timer, int_lines[4:0], m_ipsw};
    endfunction

    // Event number from the rules: lowest sync bit, syscall, highest pending enabled IP.
    function automatic logic [7:0] m_code();
        logic [31:0] req, low, pend;
        req  = {12'h0, excp_req};
        pend = {24'h0, m_ip() & m_im};
        if (req != 0) begin
            low = req & (~req + 32'd1);
            return 8'($clog2(low));
        end
        if (syscall) return 8'h50;
        if (m_ie && !m_exl && pend != 0) return 8'h20 + 8'($clog2(pend + 32'd1) - 1);
        return 8'hFF;
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        case (a)
`ifdef EXP_CTRL_TIMER_EN
            5'd9:  return m_count;
            5'd11: return m_cmp;
`endif
            5'd12: return {16'h0, m_im, 6'h0, m_exl, m_ie};
            5'd13: return {16'h0, m_ip(), 1'b0, m_exc, 2'b00};
            5'd14: return m_epc;
            default: return 32'h0;
        endcase
    endfunction

    always @(posedge clk or negedge rst) begin
        logic [7:0]  code;
        logic        tk, old_exl;
        logic [31:0] nc;
        if (!rst) begin
            m_ie = 0; m_exl = 0; m_im = 0; m_ipsw = 0; m_exc = 0;
            m_epc = 0; m_count = 0; m_cmp = 32'hFFFF_FFFF; m_timer = 0;
        end else begin
            code    = m_code();
            tk      = (code != 8'hFF);
            old_exl = m_exl;
`ifdef EXP_CTRL_TIMER_EN
            nc = (mtc0_we && mtc0_addr == 5'd9) ? mtc0_data : m_count + 32'd1;
            if (mtc0_we && mtc0_addr == 5'd11) begin
                m_timer = 0;
                m_cmp   = mtc0_data;
            end else if (nc == m_cmp) begin
                m_timer = 1;
            end
            m_count = nc;
`endif
            if (mtc0_we && mtc0_addr == 5'd12) begin
                m_ie = mtc0_data[0]; m_exl = mtc0_data[1]; m_im = mtc0_data[15:8];
            end
            if (mtc0_we && mtc0_addr == 5'd13) m_ipsw = mtc0_data[9:8];
            if (mtc0_we && mtc0_addr == 5'd14) m_epc = mtc0_data;
            if (eret && !tk) m_exl = 0;
            if (tk) begin
                if (code == 8'h50) m_exc = 5'd8;
                else if (code >= 8'h20) m_exc = 5'd0;
                else m_exc = code[4:0];
                if (!old_exl) m_epc = excp_pc;
                m_exl = 1;
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (rst) begin
            check("exp_no", {24'h0, exp_no}, {24'h0, m_code()});
            check("epc", epc, m_epc);
            check("mfc0", mfc0_data, m_read(mfc0_addr));
            check("timer_int", {31'h0, timer_int}, {31'h0, m_timer});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        mtc0_we = 1'b1; mtc0_addr = a; mtc0_data = d;
        step();
        mtc0_we = 1'b0;
    endtask

    logic [4:0] addr_tbl [8] = '{5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd0, 5'd3, 5'd31};

    initial begin
        // reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst exp_no", {24'h0, exp_no}, 32'hFF);
        check("rst epc", epc, 32'h0);
        check("rst mfc0", mfc0_data, 32'h0);
        check("rst timer", {31'h0, timer_int}, 32'h0);
        rst = 1'b1;
        step();

        // lowest-index sync request wins; EPC/EXL/ExcCode one edge later
        excp_req = 20'h00012; excp_pc = 32'h100;
        #1 check("t1 exp_no", {24'h0, exp_no}, 32'h01);
        step();
        excp_req = '0; mfc0_addr = 5'd14;
        #1 check("t1 epc", mfc0_data, 32'h100);
        mfc0_addr = 5'd12;
        #1 check("t1 status", mfc0_data, 32'h2);
        mfc0_addr = 5'd13;
        #1 check("t1 cause", mfc0_data, 32'h4);

        // nested exception keeps EPC
        excp_req = 20'h1 << 5; excp_pc = 32'h200;
        #1 check("t4 exp_no", {24'h0, exp_no}, 32'h05);
        step();
        excp_req = '0; mfc0_addr = 5'd14;
        #1 check("t4 epc", mfc0_data, 32'h100);
        mfc0_addr = 5'd13;
        #1 check("t4 cause", mfc0_data, 32'h14);

        // interrupt entry, blocked while EXL, re-taken after eret
        eret = 1'b1;
        wr(5'd12, 32'h0000_8001);
        eret = 1'b0; int_lines = 6'h20;
        #1 check("t2 exp_no", {24'h0, exp_no}, 32'h27);
        step();
        #1 check("t2 blocked", {24'h0, exp_no}, 32'hFF);
        check("t2 cause", mfc0_data, 32'h8000);
        eret = 1'b1;
        step();
        eret = 1'b0;
        #1 check("t2 again", {24'h0, exp_no}, 32'h27);
        step();
        eret = 1'b1;
        step();
        eret = 1'b0;

        // sync > syscall > interrupt; syscall alone still reported with EXL set
        excp_req = 20'h1 << 3; syscall = 1'b1;
        #1 check("t3 prio", {24'h0, exp_no}, 32'h03);
        step();
        excp_req = '0; int_lines = '0;
        #1 check("t3 syscall", {24'h0, exp_no}, 32'h50);
        step();
        syscall = 1'b0; mfc0_addr = 5'd13;
        #1 check("t3 exccode", mfc0_data, 32'h20);

`ifdef EXP_CTRL_TIMER_EN
        // timer match, clear on COMPARE write, COUNT wrap
        mfc0_addr = 5'd9;
        wr(5'd11, 32'd5);
        wr(5'd9, 32'd0);
        repeat (4) step();
        #1 check("t5 count4", mfc0_data, 32'd4);
        check("t5 timer0", {31'h0, timer_int}, 32'h0);
        step();
        #1 check("t5 count5", mfc0_data, 32'd5);
        check("t5 timer1", {31'h0, timer_int}, 32'h1);
        wr(5'd11, 32'd1000);
        #1 check("t5 clear", {31'h0, timer_int}, 32'h0);
        wr(5'd9, 32'hFFFF_FFFF);
        #1 check("t5 max", mfc0_data, 32'hFFFF_FFFF);
        step();
        #1 check("t5 wrap", mfc0_data, 32'h0);
`endif

        // asynchronous reset with EXL set (and timer set when present)
        eret = 1'b1;
        step();
        eret = 1'b0;
        excp_req = 20'h1 << 2; excp_pc = 32'h300;
        step();
        excp_req = '0;
`ifdef EXP_CTRL_TIMER_EN
        wr(5'd11, 32'd50);
        wr(5'd9, 32'd50);
        #1 check("t6 timer pre", {31'h0, timer_int}, 32'h1);
`endif
        mfc0_addr = 5'd12;
        #1 check("t6 status pre", mfc0_data, 32'h8003);
        check("t6 epc pre", epc, 32'h300);
        rst = 1'b0;
        #1 check("t6 exp_no", {24'h0, exp_no}, 32'hFF);
        check("t6 epc", epc, 32'h0);
        check("t6 status", mfc0_data, 32'h0);
        check("t6 timer", {31'h0, timer_int}, 32'h0);
        mfc0_addr = 5'd13;
        #1 check("t6 cause", mfc0_data, 32'h0);
        mfc0_addr = 5'd9;
        #1 check("t6 count", mfc0_data, 32'h0);
        #2 rst = 1'b1;
        step();

        // randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            excp_req = '0;
            if ($urandom_range(0, 9) == 0)
                excp_req = $urandom_range(0, 1) ? 20'(32'h1 << $urandom_range(0, 19)) : 20'($urandom);
            syscall = ($urandom_range(0, 11) == 0);
            if ($urandom_range(0, 7) == 0) int_lines = 6'($urandom);
            eret = ($urandom_range(0, 5) == 0);
            excp_pc = $urandom;
            mtc0_we = ($urandom_range(0, 4) == 0);
            mtc0_addr = addr_tbl[$urandom_range(0, 7)];
            case (mtc0_addr)
                5'd9:  mtc0_data = $urandom_range(0, 3) == 0 ? 32'hFFFF_FFF0 + $urandom_range(0, 15)
                                                              : 32'($urandom_range(0, 30));
                5'd11: mtc0_data = 32'($urandom_range(0, 40));
                5'd12: mtc0_data = $urandom & 32'h0000_FF03;
                5'd13: mtc0_data = $urandom & 32'h0000_0300;
                default: mtc0_data = $urandom;
            endcase
            mfc0_addr = addr_tbl[$urandom_range(0, 7)];
            step();
        end
        mtc0_we = 1'b0; eret = 1'b0; syscall = 1'b0; excp_req = '0;
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
